draining_level_counter: RTL and testbench

- Tank-level down counter for the irrigation system; the drain-side counterpart of the filling counter.
- Loads a level (000-100) in three BCD digits, then counts down one unit per prescaled tick while irrigation is active.
- Flags the empty condition when it reaches 000.
- Drives the same 7-segment BCD digit path as the filling counter: units, tens, hundreds.

---
 rtl/draining_level_counter.sv | 168 ++++++++++++++++
 tb/tb_draining_level_counter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/draining_level_counter.sv
// Tank-level BCD down counter with prescaled drain ticks and empty detection.
// Optional low-level alarm enabled by defining DRAIN_LOW_ALARM_EN.
module draining_level_counter #(
  parameter int unsigned TICK_DIV  = 4,
  parameter int unsigned LOW_LEVEL = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_u,
  input  logic [3:0] load_t,
  input  logic       load_h,
  input  logic       activateIrrigation,
  output logic [3:0] units,
  output logic [3:0] tens,
  output logic       hundreds,
  output logic       draining,
  output logic       empty,
  output logic       empty_pulse,
  output logic       load_err,
  output logic       low_alarm
);

  if (TICK_DIV < 1 || TICK_DIV > 255 || LOW_LEVEL < 1 || LOW_LEVEL > 99) begin : g_bad_param
    $error("draining_level_counter: parameter out of range");
  end

  localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_DRAIN = 2'd1
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] units_q, units_d;
  logic [3:0] tens_q, tens_d;
  logic       hund_q, hund_d;
  logic [7:0] div_q, div_d;
  logic       empty_q, empty_d;
  logic       drain_q, drain_d;
  logic       pulse_q, pulse_d;
  logic       err_q, err_d;

  always_comb begin
    state_d = state_q;
    units_d = units_q;
    tens_d  = tens_q;
    hund_d  = hund_q;
    div_d   = div_q;
    pulse_d = 1'b0;
    err_d   = 1'b0;
    if (load) begin
      if (load_u > 4'd9 || load_t > 4'd9) begin
        err_d = 1'b1;
      end else begin
        div_d = 8'd0;
        if (load_h) begin
          hund_d  = 1'b1;
          tens_d  = 4'd0;
          units_d = 4'd0;
        end else begin
          hund_d  = 1'b0;
          tens_d  = load_t;
          units_d = load_u;
        end
        state_d = (load_h || load_t != 4'd0 || load_u != 4'd0)
                  ? S_DRAIN : S_EMPTY;
      end
    end else begin
      case (state_q)
        S_DRAIN: begin
          if (activateIrrigation) begin
            if (div_q == TICK_LAST) begin
              div_d = 8'd0;
              if (units_q != 4'd0) begin
                units_d = units_q - 4'd1;
              end else if (tens_q != 4'd0) begin
                units_d = 4'd9;
                tens_d  = tens_q - 4'd1;
              end else begin
                hund_d  = 1'b0;
                tens_d  = 4'd9;
                units_d = 4'd9;
              end
              // 001 is the only level that borrows down to zero
              if (!hund_q && tens_q == 4'd0 && units_q == 4'd1) begin
                state_d = S_EMPTY;
                pulse_d = 1'b1;
              end
            end else begin
              div_d = div_q + 8'd1;
            end
          end
        end
        S_EMPTY: begin
          div_d = 8'd0;
        end
        default: begin
          state_d = S_EMPTY;
          div_d   = 8'd0;
          units_d = 4'd0;
          tens_d  = 4'd0;
          hund_d  = 1'b0;
        end
      endcase
    end
    empty_d = (units_d == 4'd0) && (tens_d == 4'd0) && !hund_d;
    drain_d = (state_d == S_DRAIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_EMPTY;
      units_q <= 4'd0;
      tens_q  <= 4'd0;
      hund_q  <= 1'b0;
      div_q   <= 8'd0;
      empty_q <= 1'b1;
      drain_q <= 1'b0;
      pulse_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      units_q <= units_d;
      tens_q  <= tens_d;
      hund_q  <= hund_d;
      div_q   <= div_d;
      empty_q <= empty_d;
      drain_q <= drain_d;
      pulse_q <= pulse_d;
      err_q   <= err_d;
    end
  end

`ifdef DRAIN_LOW_ALARM_EN
  logic [6:0] lvl_bin;
  logic       alarm_d, alarm_q;

  always_comb begin
    lvl_bin = (hund_d ? 7'd100 : 7'd0)
            + 7'(tens_d) * 7'd10
            + 7'(units_d);
    alarm_d = (lvl_bin != 7'd0) && (int'(lvl_bin) < int'(LOW_LEVEL));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign low_alarm = alarm_q;
`else
  assign low_alarm = 1'b0;
`endif

  assign units       = units_q;
  assign tens        = tens_q;
  assign hundreds    = hund_q;
  assign draining    = drain_q;
  assign empty       = empty_q;
  assign empty_pulse = pulse_q;
  assign load_err    = err_q;

endmodule

// File: tb/tb_draining_level_counter.sv
// Random + directed bench for draining_level_counter against an
// integer tank-level model.
module tb_draining_level_counter;

  localparam int TD  = 4;
  localparam int LOW = 10;

  logic       clk = 1'b0;
  logic       reset, load, load_h, en;
  logic [3:0] load_u, load_t;
  logic [3:0] units, tens;
  logic       hundreds, draining, empty, empty_pulse, load_err, low_alarm;

  int checks   = 0;
  int failures = 0;

  int m_lvl   = 0;
  int m_div   = 0;
  bit m_pulse = 0;
  bit m_err   = 0;

  draining_level_counter #(.TICK_DIV(TD), .LOW_LEVEL(LOW)) dut (
    .clk(clk), .reset(reset), .load(load),
    .load_u(load_u), .load_t(load_t), .load_h(load_h),
    .activateIrrigation(en),
    .units(units), .tens(tens), .hundreds(hundreds),
    .draining(draining), .empty(empty), .empty_pulse(empty_pulse),
    .load_err(load_err), .low_alarm(low_alarm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dut_lvl();
    return (hundreds ? 100 : 0) + int'(tens) * 10 + int'(units);
  endfunction

  function automatic bit exp_alarm();
`ifdef DRAIN_LOW_ALARM_EN
    return (m_lvl > 0) && (m_lvl < LOW);
`else
    return 1'b0;
`endif
  endfunction

  // Drive one cycle of inputs at the negedge, advance the model, then
  // compare every output on the following negedge.
  task automatic step(input bit r, input bit ld, input int u,
                      input int t, input bit h, input bit e);
    reset  = r;
    load   = ld;
    load_u = 4'(u);
    load_t = 4'(t);
    load_h = h;
    en     = e;
    m_pulse = 0;
    m_err   = 0;
    if (r) begin
      m_lvl = 0;
      m_div = 0;
    end else if (ld) begin
      if (u > 9 || t > 9) begin
        m_err = 1;
      end else begin
        m_lvl = h ? 100 : t * 10 + u;
        m_div = 0;
      end
    end else if (m_lvl > 0 && e) begin
      if (m_div == TD - 1) begin
        m_div = 0;
        m_lvl--;
        m_pulse = (m_lvl == 0);
      end else begin
        m_div++;
      end
    end
    @(negedge clk);
    chk("units", int'(units), m_lvl % 10);
    chk("tens", int'(tens), (m_lvl / 10) % 10);
    chk("hundreds", int'(hundreds), m_lvl / 100);
    chk("empty", int'(empty), int'(m_lvl == 0));
    chk("draining", int'(draining), int'(m_lvl != 0));
    chk("empty_pulse", int'(empty_pulse), int'(m_pulse));
    chk("load_err", int'(load_err), int'(m_err));
    chk("low_alarm", int'(low_alarm), int'(exp_alarm()));
  endtask

  task automatic idle(input int n, input bit e);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, e);
  endtask

  initial begin
    reset = 1; load = 0; load_u = 0; load_t = 0; load_h = 0; en = 0;
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0);
    idle(10, 1);
    chk("idle_level", dut_lvl(), 0);

    step(0, 1, 0, 0, 1, 1);
    chk("load100", dut_lvl(), 100);
    idle(3, 1);
    chk("no_dec_early", dut_lvl(), 100);
    idle(1, 1);
    chk("first_dec_099", dut_lvl(), 99);
    idle(4, 1);
    chk("second_dec_098", dut_lvl(), 98);

    step(0, 1, 0, 1, 0, 1);
    idle(4, 1);
    chk("tens_borrow_009", dut_lvl(), 9);
    idle(36, 1);
    chk("drained_000", dut_lvl(), 0);
    chk("pulse_on_empty", int'(empty_pulse), 1);
    idle(5, 1);
    chk("stays_000", dut_lvl(), 0);

    step(0, 1, 0, 5, 0, 0);
    idle(6, 1);
    chk("pause_049", dut_lvl(), 49);
    idle(20, 0);
    chk("frozen_049", dut_lvl(), 49);
    idle(1, 1);
    chk("resume_hold", dut_lvl(), 49);
    idle(1, 1);
    chk("resume_048", dut_lvl(), 48);

    step(0, 1, 10, 0, 0, 0);
    chk("bad_load_err", int'(load_err), 1);
    chk("bad_load_level", dut_lvl(), 48);
    step(0, 1, 2, 3, 1, 0);
    chk("clamp_100", dut_lvl(), 100);
    step(0, 1, 0, 0, 0, 0);
    chk("load_zero_empty", int'(empty), 1);

    step(0, 1, 2, 1, 0, 1);
    idle(3, 1);
    step(0, 1, 0, 5, 0, 1);
    chk("load_beats_dec", dut_lvl(), 50);

    step(0, 1, 2, 1, 0, 1);
    idle(60, 1);
    chk("alarm_run_empty", dut_lvl(), 0);

    step(0, 1, 5, 3, 0, 1);
    idle(7, 1);
    step(1, 0, 0, 0, 0, 1);
    chk("reset_mid_drain", dut_lvl(), 0);

    for (int i = 0; i < 3000; i++) begin
      bit r, ld, h, e;
      int u, t;
      r  = ($urandom_range(0, 299) == 0);
      ld = ($urandom_range(0, 14) == 0);
      e  = ($urandom_range(0, 3) != 0);
      h  = ($urandom_range(0, 5) == 0);
      u  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15)
                                        : $urandom_range(0, 9);
      t  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15)
                                        : $urandom_range(0, 2);
      step(r, ld, u, t, h, e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
